// File: rtl/motor_pwm_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | motor_pwm_driver                                                       |
// | Sign-magnitude command to slew-limited H-bridge PWM pair. Optional     |
// | command watchdog enabled by defining MOTOR_WDOG_EN.                    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module motor_pwm_driver #(
   parameter int PRESCALE     = 4,
   parameter int RAMP_STEP    = 4,
   parameter int DEAD_PERIODS = 2,
   parameter int WDOG_PERIODS = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cmd,
   input  logic       cmd_strobe,
   output logic       pwm_a,
   output logic       pwm_b,
   output logic       dir_out,
   output logic [6:0] duty_now,
   output logic       busy,
   output logic       fault_timeout
);
   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_RUN       = 2'd1;
   localparam logic [1:0] c_RAMP_DOWN = 2'd2;
   localparam logic [1:0] c_DEADTIME  = 2'd3;

   localparam int         c_PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int         c_DEAD_W    = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
   localparam logic [6:0] c_STEP      = 7'(RAMP_STEP);
   localparam logic [c_DEAD_W-1:0] c_DEAD_LAST = c_DEAD_W'(DEAD_PERIODS - 1);
   localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(PRESCALE - 1);

   logic [c_PRE_W-1:0]  r_pre;
   logic [6:0]          r_cnt;
   logic                w_tick;
   logic                w_bound;
   logic [6:0]          r_tgt_mag;
   logic                r_tgt_dir;
   logic [6:0]          w_eff_mag;
   logic [1:0]          r_state, w_state_nx;
   logic [6:0]          r_duty, w_duty_nx;
   logic                r_dir, w_dir_nx;
   logic [c_DEAD_W-1:0] r_dead, w_dead_nx;
   logic [6:0]          w_toward;
   logic [6:0]          w_decay;
   logic                w_rev;
   logic                w_pwm;
   logic                r_pwm_a, r_pwm_b;

   assign w_tick  = (r_pre == c_PRE_LAST);
   assign w_bound = w_tick && (r_cnt == 7'd126);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
         r_cnt <= (r_cnt == 7'd126) ? 7'd0 : r_cnt + 7'd1;
      end else begin
         r_pre <= r_pre + c_PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tgt_mag <= '0;
         r_tgt_dir <= 1'b0;
      end else if (cmd_strobe) begin
         r_tgt_mag <= cmd[6:0];
         r_tgt_dir <= cmd[7];
      end
   end

`ifdef MOTOR_WDOG_EN
   localparam int c_WD_W = $clog2(WDOG_PERIODS + 1);
   localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(WDOG_PERIODS);

   logic [c_WD_W-1:0] r_wdog;
   logic              r_fault;

   // A strobe always wins over a boundary so a live link never faults.
   always_ff @(posedge clk) begin
      if (reset || cmd_strobe) begin
         r_wdog  <= '0;
         r_fault <= 1'b0;
      end else if (w_bound && (r_wdog != c_WD_MAX)) begin
         r_wdog <= r_wdog + c_WD_W'(1);
         if (r_wdog == c_WD_MAX - c_WD_W'(1))
            r_fault <= 1'b1;
      end
   end

   assign w_eff_mag     = r_fault ? 7'd0 : r_tgt_mag;
   assign fault_timeout = r_fault;
`else
   assign w_eff_mag     = r_tgt_mag;
   assign fault_timeout = 1'b0;
`endif

   always_comb begin
      w_toward = r_duty;
      if (w_eff_mag > r_duty)
         w_toward = ((w_eff_mag - r_duty) > c_STEP) ? r_duty + c_STEP : w_eff_mag;
      else if (w_eff_mag < r_duty)
         w_toward = ((r_duty - w_eff_mag) > c_STEP) ? r_duty - c_STEP : w_eff_mag;
   end

   assign w_decay = (r_duty > c_STEP) ? r_duty - c_STEP : 7'd0;
   // Zero magnitude is "stop" and never requests a reversal.
   assign w_rev   = (w_eff_mag != 7'd0) && (r_tgt_dir != r_dir);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_duty  <= '0;
         r_dir   <= 1'b0;
         r_dead  <= '0;
      end else if (w_bound) begin
         r_state <= w_state_nx;
         r_duty  <= w_duty_nx;
         r_dir   <= w_dir_nx;
         r_dead  <= w_dead_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_duty_nx  = r_duty;
      w_dir_nx   = r_dir;
      w_dead_nx  = r_dead;
      case (r_state)
         c_IDLE: begin
            if (w_rev) begin
               w_state_nx = c_DEADTIME;
               w_dead_nx  = '0;
            end else if (w_eff_mag != 7'd0) begin
               w_state_nx = c_RUN;
               w_duty_nx  = w_toward;
            end
         end
         c_RUN: begin
            if (w_rev) begin
               w_duty_nx  = w_decay;
               w_state_nx = (w_decay == 7'd0) ? c_DEADTIME : c_RAMP_DOWN;
               w_dead_nx  = '0;
            end else begin
               w_duty_nx = w_toward;
               if (w_toward == 7'd0)
                  w_state_nx = c_IDLE;
            end
         end
         c_RAMP_DOWN: begin
            if ((w_eff_mag != 7'd0) && !w_rev) begin
               w_state_nx = c_RUN;
               w_duty_nx  = w_toward;
            end else begin
               w_duty_nx = w_decay;
               w_dead_nx = '0;
               if (w_decay == 7'd0)
                  w_state_nx = c_DEADTIME;
            end
         end
         default: begin
            // Dead time runs to completion; duty is already 0 so w_toward is the first step.
            w_duty_nx = 7'd0;
            if (r_dead == c_DEAD_LAST) begin
               if (w_eff_mag != 7'd0) begin
                  w_dir_nx   = r_tgt_dir;
                  w_duty_nx  = w_toward;
                  w_state_nx = c_RUN;
               end else begin
                  w_state_nx = c_IDLE;
               end
            end else begin
               w_dead_nx = r_dead + c_DEAD_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      busy  = (r_state == c_RAMP_DOWN) || (r_state == c_DEADTIME);
      w_pwm = (r_cnt < r_duty);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pwm_a <= 1'b0;
         r_pwm_b <= 1'b0;
      end else begin
         r_pwm_a <= w_pwm & ~r_dir;
         r_pwm_b <= w_pwm & r_dir;
      end
   end

   assign pwm_a    = r_pwm_a;
   assign pwm_b    = r_pwm_b;
   assign dir_out  = r_dir;
   assign duty_now = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_motor_pwm_driver                                                    |
// | Scoreboard bench: expected duty/dir/busy/fault snapshots are queued.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_motor_pwm_driver;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] cmd = 8'h00;
   logic       cmd_strobe = 1'b0;
   logic       pwm_a, pwm_b, dir_out, busy, fault_timeout;
   logic [6:0] duty_now;

   motor_pwm_driver #(
      .PRESCALE(1), .RAMP_STEP(4), .DEAD_PERIODS(2), .WDOG_PERIODS(8)
   ) dut (
      .clk(clk), .reset(reset), .cmd(cmd), .cmd_strobe(cmd_strobe),
      .pwm_a(pwm_a), .pwm_b(pwm_b), .dir_out(dir_out), .duty_now(duty_now),
      .busy(busy), .fault_timeout(fault_timeout)
   );

   always #5 clk = ~clk;

   typedef logic [9:0] snap_t;   // {duty[6:0], dir, busy, fault}
   snap_t exp_q[$];
   snap_t prev_s, cur_s, exp_s;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    overlap = 0;
   logic  mon_en  = 1'b0;
`ifdef MOTOR_WDOG_EN
   logic  ka_en   = 1'b0;
   int    ka_cnt  = 0;
`endif

   // Monitor: every change of the applied state must match the next queued snapshot.
   always @(posedge clk) begin
      #1;
      if (pwm_a && pwm_b) overlap++;
      cur_s = {duty_now, dir_out, busy, fault_timeout};
      if (mon_en && (cur_s !== prev_s)) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change got duty=%0d dir=%0b busy=%0b fault=%0b (no change expected)",
                     cur_s[9:3], cur_s[2], cur_s[1], cur_s[0]);
         end else begin
            exp_s = exp_q.pop_front();
            if (cur_s !== exp_s) begin
               n_fail++;
               $display("FAIL step got duty=%0d dir=%0b busy=%0b fault=%0b want duty=%0d dir=%0b busy=%0b fault=%0b",
                        cur_s[9:3], cur_s[2], cur_s[1], cur_s[0],
                        exp_s[9:3], exp_s[2], exp_s[1], exp_s[0]);
            end
         end
      end
      prev_s = cur_s;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
`ifdef MOTOR_WDOG_EN
         if (ka_en) begin
            ka_cnt++;
            if (ka_cnt >= 300) begin
               ka_cnt = 0;
               cmd_strobe = 1'b1;
               @(negedge clk);
               cmd_strobe = 1'b0;
            end
         end
`endif
      end
   endtask

   task automatic strobe(input logic [7:0] c);
      @(negedge clk);
      cmd        = c;
      cmd_strobe = 1'b1;
      @(negedge clk);
      cmd_strobe = 1'b0;
   endtask

   task automatic push(input int d, input logic dr, input logic bz, input logic ft);
      exp_q.push_back({7'(d), dr, bz, ft});
   endtask

   // Hand-derived ramp: steps of 4, last step clipped to the target.
   task automatic push_ramp(input int from, input int to, input logic dr, input logic bz,
                            input logic ft);
      int d;
      d = from;
      while (d != to) begin
         if (to > d) d = (to - d > 4) ? d + 4 : to;
         else        d = (d - to > 4) ? d - 4 : to;
         push(d, dr, bz, ft);
      end
   endtask

   task automatic check(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 8000) begin
         tick(1);
         t++;
      end
      check({name, "_drain_remaining"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic measure(input string name, input int want_a, input int want_b);
      int ca, cb;
      ca = 0;
      cb = 0;
      tick(2);
      for (int i = 0; i < 127; i++) begin
         tick(1);
         ca += int'(pwm_a);
         cb += int'(pwm_b);
      end
      check({name, "_pwm_a_high"}, ca, want_a);
      check({name, "_pwm_b_high"}, cb, want_b);
   endtask

   initial begin
      int t;
      tick(4);
      check("rst_pwm_a", int'(pwm_a), 0);
      check("rst_pwm_b", int'(pwm_b), 0);
      check("rst_duty", int'(duty_now), 0);
      check("rst_dir", int'(dir_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_fault", int'(fault_timeout), 0);
      reset  = 1'b0;
      mon_en = 1'b1;
`ifdef MOTOR_WDOG_EN
      ka_en = 1'b1;
`endif

      push_ramp(0, 64, 1'b0, 1'b0, 1'b0);
      strobe(8'h40);
      wait_drain("fwd_64");
      measure("fwd_64", 64, 0);
      check("fwd_64_busy", int'(busy), 0);

      push_ramp(64, 127, 1'b0, 1'b0, 1'b0);
      strobe(8'h7F);
      wait_drain("fwd_127");
      measure("fwd_127", 127, 0);

      push_ramp(127, 0, 1'b0, 1'b0, 1'b0);
      strobe(8'h00);
      wait_drain("stop_from_127");
      measure("stopped", 0, 0);

      push_ramp(0, 64, 1'b0, 1'b0, 1'b0);
      strobe(8'h40);
      wait_drain("fwd_64_again");
      push_ramp(64, 20, 1'b0, 1'b0, 1'b0);
      strobe(8'h14);
      wait_drain("fwd_20");

      // Zero magnitude with direction bit set: plain stop, no reversal.
      push_ramp(20, 0, 1'b0, 1'b0, 1'b0);
      strobe(8'h80);
      wait_drain("stop_dir1");
      tick(3 * 127);
      check("stop_dir1_busy", int'(busy), 0);
      check("stop_dir1_dir", int'(dir_out), 0);

      push_ramp(0, 64, 1'b0, 1'b0, 1'b0);
      strobe(8'h40);
      wait_drain("fwd_64_pre_rev");

      push_ramp(64, 0, 1'b0, 1'b1, 1'b0);
      push(4, 1'b1, 1'b0, 1'b0);
      push_ramp(4, 64, 1'b1, 1'b0, 1'b0);
      strobe(8'hC0);
      wait_drain("reverse");
      measure("rev_64", 0, 64);

      push_ramp(64, 36, 1'b1, 1'b0, 1'b0);
      strobe(8'hA4);
      wait_drain("rev_36");
      t = 0;
      while (pwm_b !== 1'b1 && t < 300) begin
         tick(1);
         t++;
      end
      check("pre_reset_pwm_b", int'(pwm_b), 1);
      push(0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset_pwm_a", int'(pwm_a), 0);
      check("mid_reset_pwm_b", int'(pwm_b), 0);
      check("mid_reset_duty", int'(duty_now), 0);
      check("mid_reset_dir", int'(dir_out), 0);
      reset = 1'b0;
      wait_drain("reset");

`ifdef MOTOR_WDOG_EN
      push_ramp(0, 64, 1'b0, 1'b0, 1'b0);
      strobe(8'h40);
      wait_drain("wd_fwd_64");
      ka_en = 1'b0;
      push(64, 1'b0, 1'b0, 1'b1);
      push_ramp(64, 0, 1'b0, 1'b0, 1'b1);
      strobe(8'h40);
      wait_drain("wd_timeout");
      check("wd_fault_set", int'(fault_timeout), 1);
      push(0, 1'b0, 1'b0, 1'b0);
      push_ramp(0, 16, 1'b0, 1'b0, 1'b0);
      strobe(8'h10);
      wait_drain("wd_recover");
      check("wd_fault_clear", int'(fault_timeout), 0);
`endif

      tick(4);
      check("pwm_overlap_clks", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream consumer of one 8-bit motor command byte from the UART frame decoder; one instance per wheel (4 total).
- Converts sign-magnitude command (bit7 = direction, bits 6:0 = magnitude) into H-bridge PWM pair with slew-rate limiting and shoot-through-safe direction reversal.
- Duty changes only on PWM period boundaries, so no runt pulses.

Parameters:
- PRESCALE, 4, clk cycles per PWM tick (>=1).
- RAMP_STEP, 4, max duty change per PWM period (1..127).
- DEAD_PERIODS, 2, full PWM periods both outputs held low on reversal (>=1).
- WDOG_PERIODS, 1024, PWM periods without cmd_strobe before timeout (watchdog build only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd  in  8  [7] direction, [6:0] magnitude
- cmd_strobe  in  1  one-cycle pulse: cmd holds a new value
- pwm_a  out  1  H-bridge forward input
- pwm_b  out  1  H-bridge reverse input
- dir_out  out  1  currently applied direction
- duty_now  out  7  currently applied duty
- busy  out  1  high in RAMP_DOWN or DEADTIME
- fault_timeout  out  1  watchdog expired

Behaviour:
- Reset: all outputs 0, prescaler 0, PWM counter 0, target 0, state IDLE. Reset mid-period drives pwm_a/pwm_b low on the next clock.
- Target capture: on cmd_strobe, tgt_mag <= cmd[6:0] and tgt_dir <= cmd[7], one clock latency. Without a strobe the target is held.
- PWM counter: advances once per PRESCALE clks, counts 0..126 and wraps, so a period is 127 ticks.
- pwm = (counter < duty_now). Duty 0 gives constant low; duty 127 gives constant high.
- pwm_a = pwm & ~dir_out; pwm_b = pwm & dir_out. Both are registered. pwm_a and pwm_b are never high together.
- Boundary event: the tick where counter wraps 126->0. All duty, dir and state updates happen only here.
- A magnitude of 0 means "stop". Direction is ignored in that case and causes no reversal.
- State IDLE (duty_now == 0):
  - tgt_mag > 0 with tgt_dir == dir_out -> RUN.
  - tgt_mag > 0 with tgt_dir != dir_out -> DEADTIME.
- State RUN, at each boundary:
  - tgt_mag > 0 with tgt_dir != dir_out -> RAMP_DOWN.
  - Otherwise duty_now moves toward tgt_mag by min(RAMP_STEP, |diff|) with no overshoot.
  - If duty_now reaches 0 with tgt_mag == 0 -> IDLE.
- State RAMP_DOWN: duty_now -= min(RAMP_STEP, duty_now) per boundary.
  - A new target with tgt_dir == dir_out -> RUN (ramp toward it).
  - duty_now == 0 -> DEADTIME.
- State DEADTIME: duty 0 and both outputs low for exactly DEAD_PERIODS boundaries. It always completes, even if the target changes.
  - On expiry: if tgt_mag > 0, dir_out <= tgt_dir and -> RUN; else dir_out unchanged and -> IDLE.
- A strobe and a boundary in the same clk: the boundary uses the old target; the new target takes effect at the next boundary.

Optional Feature:
- Macro MOTOR_WDOG_EN.
- Defined:
  - Period counter clears on cmd_strobe and increments per boundary, saturating.
  - Reaching WDOG_PERIODS sets fault_timeout=1 and forces the effective target magnitude to 0, so duty ramps down normally.
  - The next cmd_strobe clears the fault and the counter and applies the new cmd.
- Undefined: fault_timeout tied 0; target held indefinitely.

Test Plan:
Bench parameters: PRESCALE=1, RAMP_STEP=4, DEAD_PERIODS=2, WDOG_PERIODS=8.
- Reset, strobe cmd=0x40 -> duty_now 4,8,...,64 over 16 boundaries; afterwards pwm_a high 64 of 127 clks per period; pwm_b stays 0; busy 0.
- From duty 64, strobe 0x7F -> reaches 127 after 16 boundaries, pwm_a constant 1; then strobe 0x00 -> ramps to 0, pwm_a constant 0, state IDLE.
- From dir 0 duty 64, strobe 0xC0 -> busy 1, ramp to 0 in 16 periods, 2 periods both low, dir_out=1, pwm_b ramps to 64; pwm_a&pwm_b never 1 (assert every clk).
- From dir 0 duty 20, strobe 0x80 -> ramps 16,12,...,0; dir_out stays 0; no DEADTIME entered.
- Assert reset mid-ramp at duty 36 -> next clk pwm_a=pwm_b=0, duty_now=0, dir_out=0.
- (MOTOR_WDOG_EN) duty 64, no strobe for 8 boundaries -> fault_timeout=1, duty ramps to 0; strobe 0x10 -> fault clears, ramps to 16.
